seq_shift_add_multiplier: RTL and testbench

Parametrised sequential shift-and-add multiplier. It generalises the lab 4-bit hardwired-operand multiplier in three ways: a configurable operand width, operands taken from ports, and run-time selectable unsigned or two's-complement multiplication. It retains the accumulator/multiplier register pair (A:Q) and iterates one multiplier bit per clock. A start/ready/done handshake lets the top level or a test sequencer issue back-to-back operations.

---
 rtl/seq_shift_add_multiplier.sv | 146 ++++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_add_multiplier
//  Purpose  : Sequential shift-and-add multiplier with an A:Q register pair.
//             One multiplier bit is consumed per clock. Operands are unsigned
//             or two's-complement, selected per operation. A start/ready/done
//             handshake allows back-to-back operations.
//  Revision : 1.0  initial release
// ============================================================================
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Qin,
  output logic [2*WIDTH-1:0]   AQ,
  output logic                 ready,
  output logic                 done
);

  // The counter must be able to name every iteration index 0..WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Architectural registers and their next values.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] m_next;
  logic             s_reg;
  logic             s_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             done_reg;
  logic             done_next;

  // Datapath: one WIDTH+1-bit add/subtract stage.
  logic [WIDTH:0]   ax;
  logic [WIDTH:0]   mx;
  logic [WIDTH:0]   p;
  logic             last_iter;
  logic             sub_step;

  // FSM state register; reset wins over any start or running operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: A, Q, multiplicand, mode bit, counter and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg    <= '0;
      q_reg    <= '0;
      m_reg    <= '0;
      s_reg    <= 1'b0;
      cnt      <= '0;
      done_reg <= 1'b0;
    end else begin
      a_reg    <= a_next;
      q_reg    <= q_next;
      m_reg    <= m_next;
      s_reg    <= s_next;
      cnt      <= cnt_next;
      done_reg <= done_next;
    end
  end

  // Extend A and M by one bit (zero or sign) and form the partial sum P.
  // In signed mode the last multiplier bit carries negative weight, so that
  // iteration subtracts the multiplicand instead of adding it.
  always_comb begin
    ax        = s_reg ? {a_reg[WIDTH-1], a_reg} : {1'b0, a_reg};
    mx        = s_reg ? {m_reg[WIDTH-1], m_reg} : {1'b0, m_reg};
    last_iter = (cnt == LAST_ITER);
    sub_step  = s_reg & last_iter;
    p         = ax;
    if (q_reg[0]) begin
      if (sub_step) begin
        p = ax - mx;
      end else begin
        p = ax + mx;
      end
    end
  end

  // Next-state and register-update logic; every target defaults to hold.
  always_comb begin
    state_next = state;
    a_next     = a_reg;
    q_next     = q_reg;
    m_next     = m_reg;
    s_next     = s_reg;
    cnt_next   = cnt;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_next     = '0;
          q_next     = Qin;
          m_next     = M;
          s_next     = signed_mode;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        // Shift {P, Q[WIDTH-1:1]} into A:Q; P[WIDTH] becomes the new A MSB,
        // carrying the unsigned carry or the signed sign extension.
        a_next   = p[WIDTH:1];
        q_next   = {p[0], q_reg[WIDTH-1:1]};
        cnt_next = cnt + CNT_ONE;
        if (last_iter) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign AQ    = {a_reg, q_reg};
  assign ready = (state == IDLE);
  assign done  = done_reg;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_shift_add_multiplier
//  Purpose  : Bench for seq_shift_add_multiplier at WIDTH 4, 8 and 16, with
//             an arithmetic reference model and directed literal cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start_i [3];
  logic        mode_i  [3];
  logic [31:0] m_i     [3];
  logic [31:0] q_i     [3];
  logic        rdy     [3];
  logic        dn      [3];
  logic [7:0]  aq4;
  logic [15:0] aq8;
  logic [31:0] aq16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(4)) u_w4 (
    .clock(clk), .reset(rst), .start(start_i[0]), .signed_mode(mode_i[0]),
    .M(m_i[0][3:0]), .Qin(q_i[0][3:0]), .AQ(aq4), .ready(rdy[0]), .done(dn[0]));

  seq_shift_add_multiplier #(.WIDTH(8)) u_w8 (
    .clock(clk), .reset(rst), .start(start_i[1]), .signed_mode(mode_i[1]),
    .M(m_i[1][7:0]), .Qin(q_i[1][7:0]), .AQ(aq8), .ready(rdy[1]), .done(dn[1]));

  seq_shift_add_multiplier #(.WIDTH(16)) u_w16 (
    .clock(clk), .reset(rst), .start(start_i[2]), .signed_mode(mode_i[2]),
    .M(m_i[2][15:0]), .Qin(q_i[2][15:0]), .AQ(aq16), .ready(rdy[2]), .done(dn[2]));

  function automatic int wid(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 8 : 16);
  endfunction

  function automatic logic [63:0] get_aq(input int k);
    if (k == 0) return {56'b0, aq4};
    if (k == 1) return {48'b0, aq8};
    return {32'b0, aq16};
  endfunction

  // Exact product of two w-bit operands, reduced to 2w bits.
  function automatic logic [63:0] ref_product(input int w, input logic s,
                                              input logic [31:0] m, input logic [31:0] q);
    longint a;
    longint b;
    longint mask;
    longint mask2;
    mask  = (longint'(1) << w) - 1;
    mask2 = (longint'(1) << (2 * w)) - 1;
    a = longint'(m) & mask;
    b = longint'(q) & mask;
    if (s && m[w-1]) a = a - (longint'(1) << w);
    if (s && q[w-1]) b = b - (longint'(1) << w);
    return 64'((a * b) & mask2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is either idle or has a number of clocks left until its
  // product is due; the product itself is plain integer arithmetic.
  bit          model_on = 1'b0;
  int          busy     [3];
  logic [63:0] exp_aq   [3];
  logic        exp_done [3];
  logic [63:0] pend     [3];

  always @(posedge clk) begin
    if (rst) begin
      model_on <= 1'b1;
      for (int k = 0; k < 3; k++) begin
        busy[k]     <= 0;
        exp_aq[k]   <= '0;
        exp_done[k] <= 1'b0;
      end
    end else if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        if (busy[k] > 0) begin
          busy[k]     <= busy[k] - 1;
          exp_done[k] <= (busy[k] == 1);
          if (busy[k] == 1) exp_aq[k] <= pend[k];
        end else begin
          exp_done[k] <= 1'b0;
          if (start_i[k]) begin
            pend[k] <= ref_product(wid(k), mode_i[k], m_i[k], q_i[k]);
            busy[k] <= wid(k);
          end
        end
      end
    end
  end

  // Compare process: handshake every cycle, AQ whenever it must hold a result.
  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("ready[w%0d]", wid(k)), {63'b0, rdy[k]}, {63'b0, (busy[k] == 0)});
        chk($sformatf("done[w%0d]", wid(k)), {63'b0, dn[k]}, {63'b0, exp_done[k]});
        if (busy[k] == 0) chk($sformatf("aq[w%0d]", wid(k)), get_aq(k), exp_aq[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Issue one operation on instance k and wait (bounded) for done.
  task automatic run_op(input int k, input logic s, input logic [31:0] m,
                        input logic [31:0] q, input logic [63:0] expv,
                        input bit toggle, input string name);
    int n;
    int w;
    bit seen;
    logic [31:0] mask;
    w    = wid(k);
    mask = (32'h1 << w) - 1;
    @(negedge clk);
    start_i[k] = 1'b1;
    mode_i[k]  = s;
    m_i[k]     = m;
    q_i[k]     = q;
    @(negedge clk);
    chk({name, "_ready_low"}, {63'b0, rdy[k]}, 64'd0);
    start_i[k] = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < w + 4) begin
      if (toggle) begin
        m_i[k]    = $urandom & mask;
        q_i[k]    = $urandom & mask;
        mode_i[k] = $urandom_range(0, 1);
        start_i[k] = (n < w - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      n++;
      if (dn[k]) seen = 1'b1;
    end
    start_i[k] = 1'b0;
    chk({name, "_done_seen"}, {63'b0, seen}, 64'd1);
    chk({name, "_latency"}, 64'(n), 64'(w));
    chk({name, "_aq"}, get_aq(k), expv);
    chk({name, "_ready_high"}, {63'b0, rdy[k]}, 64'd1);
    @(negedge clk);
    chk({name, "_done_pulse"}, {63'b0, dn[k]}, 64'd0);
    chk({name, "_aq_hold"}, get_aq(k), expv);
  endtask

  // Bounded wait for done on instance k; returns edges waited.
  task automatic wait_done(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dn[k] && n < wid(k) + 4);
  endtask

  initial begin
    int n;
    int k;
    logic s;
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] mask;
    for (int i = 0; i < 3; i++) begin
      start_i[i] = 1'b0;
      mode_i[i]  = 1'b0;
      m_i[i]     = '0;
      q_i[i]     = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_aq", get_aq(0), 64'd0);
    chk("reset_ready", {63'b0, rdy[0]}, 64'd1);
    chk("reset_done", {63'b0, dn[0]}, 64'd0);
    rst = 1'b0;

    // Directed literal cases.
    run_op(0, 1'b0, 32'd5,  32'd7,  64'h23,   1'b0, "legacy_5x7");
    run_op(0, 1'b0, 32'd15, 32'd15, 64'hE1,   1'b0, "u4_15x15");
    run_op(0, 1'b0, 32'd0,  32'd9,  64'h00,   1'b0, "u4_0x9");
    run_op(1, 1'b0, 32'd255, 32'd255, 64'hFE01, 1'b0, "u8_255x255");
    run_op(0, 1'b1, 32'hD, 32'd5, 64'hF1,     1'b0, "s4_m3x5");
    run_op(0, 1'b1, 32'd5, 32'hD, 64'hF1,     1'b0, "s4_5xm3");
    run_op(0, 1'b1, 32'h8, 32'h8, 64'h40,     1'b0, "s4_m8xm8");
    run_op(0, 1'b1, 32'hF, 32'hF, 64'h01,     1'b0, "s4_m1xm1");
    run_op(2, 1'b1, 32'h8000, 32'h8000, 64'h4000_0000, 1'b0, "s16_min_sq");
    run_op(0, 1'b0, 32'd5,  32'd7,  64'h23,   1'b1, "busy_toggle");

    // Back-to-back with start held high: 3x6 then signed 7 x -7.
    @(negedge clk);
    start_i[0] = 1'b1; mode_i[0] = 1'b0; m_i[0] = 32'd3; q_i[0] = 32'd6;
    @(negedge clk);
    wait_done(0, n);
    chk("b2b_first_latency", 64'(n), 64'd4);
    chk("b2b_first_aq", get_aq(0), 64'h12);
    mode_i[0] = 1'b1; m_i[0] = 32'd7; q_i[0] = 32'h9;
    @(negedge clk);
    chk("b2b_accept", {63'b0, rdy[0]}, 64'd0);
    wait_done(0, n);
    chk("b2b_second_latency", 64'(n), 64'd4);
    chk("b2b_second_aq", get_aq(0), 64'hCF);
    start_i[0] = 1'b0;
    @(negedge clk);

    // Reset during iteration 2 of 5x7.
    start_i[0] = 1'b1; mode_i[0] = 1'b0; m_i[0] = 32'd5; q_i[0] = 32'd7;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_aq", get_aq(0), 64'd0);
    chk("midreset_ready", {63'b0, rdy[0]}, 64'd1);
    chk("midreset_done", {63'b0, dn[0]}, 64'd0);
    rst = 1'b0;
    run_op(0, 1'b0, 32'd5, 32'd7, 64'h23, 1'b0, "after_reset_5x7");

    // Randomised operations across all three widths.
    for (int i = 0; i < 1000; i++) begin
      k    = $urandom_range(0, 2);
      mask = (32'h1 << wid(k)) - 1;
      s    = 1'($urandom_range(0, 1));
      m    = $urandom & mask;
      q    = $urandom & mask;
      run_op(k, s, m, q, ref_product(wid(k), s, m, q), (i % 4) == 0,
             $sformatf("rand%0d_w%0d", i, wid(k)));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
